// File: rtl/uart_slip_decoder_if.sv
// uart_slip_decoder_if: byte-wide AXI4-Stream link with packet framing sidebands.
interface uart_slip_decoder_if;
    logic [7:0] tdata;
    logic       tvalid;
    logic       tready;
    logic       tlast;
    logic       tuser;
    modport master (output tdata, tvalid, tlast, tuser, input tready);
    modport slave  (input tdata, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/uart_slip_decoder.sv
// uart_slip_decoder: SLIP (RFC 1055) byte stream to AXI4-Stream packets with tlast/tuser.
// Optional frame length limit enabled by SLIP_DECODE_LEN_CHECK_EN.
module uart_slip_decoder #(
    parameter int MAX_LEN = 1518
) (
    input  logic                       clk,
    input  logic                       rst,
    uart_slip_decoder_if.slave         s_axis,
    uart_slip_decoder_if.master        m_axis,
    output logic                       error_bad_escape,
    output logic                       error_overflow
);
    localparam logic [7:0] SLIP_END     = 8'hC0;
    localparam logic [7:0] SLIP_ESC     = 8'hDB;
    localparam logic [7:0] SLIP_ESC_END = 8'hDC;
    localparam logic [7:0] SLIP_ESC_ESC = 8'hDD;

    if (MAX_LEN < 2 || MAX_LEN > 65535) begin : g_bad_max_len
        $error("uart_slip_decoder: MAX_LEN out of range 2..65535");
    end

`ifdef SLIP_DECODE_LEN_CHECK_EN
    typedef enum logic [1:0] {NORMAL, ESCAPE, DISCARD} state_t;
    logic [15:0] cnt, cnt_n;
`else
    typedef enum logic [1:0] {NORMAL, ESCAPE} state_t;
`endif

    state_t     state, state_n;
    logic [7:0] held, held_n, dec_byte;
    logic       held_v, held_v_n, err, err_n;
    logic       accept, dec, fin, fin_err, bad_esc, ovf;
    logic       emit, emit_last, emit_user;

    assign s_axis.tready = !m_axis.tvalid || m_axis.tready;
    assign accept        = s_axis.tvalid && s_axis.tready;

    always_comb begin
        state_n   = state;
        dec       = 1'b0;
        dec_byte  = s_axis.tdata;
        fin       = 1'b0;
        fin_err   = 1'b0;
        bad_esc   = 1'b0;
        ovf       = 1'b0;
        held_n    = held;
        held_v_n  = held_v;
        err_n     = err;
        emit      = 1'b0;
        emit_last = 1'b0;
        emit_user = 1'b0;
`ifdef SLIP_DECODE_LEN_CHECK_EN
        cnt_n     = cnt;
`endif
        if (accept) begin
            case (state)
                NORMAL: begin
                    fin = s_axis.tdata == SLIP_END;
                    dec = s_axis.tdata != SLIP_END && s_axis.tdata != SLIP_ESC;
                    state_n = s_axis.tdata == SLIP_ESC ? ESCAPE : NORMAL;
                end
                ESCAPE: begin
                    state_n  = NORMAL;
                    fin      = s_axis.tdata == SLIP_END;
                    fin_err  = fin;
                    dec      = s_axis.tdata == SLIP_ESC_END || s_axis.tdata == SLIP_ESC_ESC;
                    dec_byte = s_axis.tdata == SLIP_ESC_END ? SLIP_END : SLIP_ESC;
                    bad_esc  = !dec && !fin;
                end
`ifdef SLIP_DECODE_LEN_CHECK_EN
                DISCARD: begin
                    fin = s_axis.tdata == SLIP_END;
                    state_n = fin ? NORMAL : DISCARD;
                end
`endif
                default: state_n = NORMAL;
            endcase
        end
`ifdef SLIP_DECODE_LEN_CHECK_EN
        ovf = dec && cnt == 16'(MAX_LEN);
`endif
        err_n = err || bad_esc;
        if (fin) begin
            // END closes the frame: the held byte becomes the tlast beat
            emit      = held_v;
            emit_last = 1'b1;
            emit_user = err || fin_err;
            held_v_n  = 1'b0;
            err_n     = 1'b0;
`ifdef SLIP_DECODE_LEN_CHECK_EN
            cnt_n     = '0;
`endif
        end else if (ovf) begin
            emit      = 1'b1;
            emit_last = 1'b1;
            emit_user = 1'b1;
            held_v_n  = 1'b0;
            err_n     = 1'b0;
`ifdef SLIP_DECODE_LEN_CHECK_EN
            state_n   = DISCARD;
`endif
        end else if (dec) begin
            emit     = held_v;
            held_n   = dec_byte;
            held_v_n = 1'b1;
`ifdef SLIP_DECODE_LEN_CHECK_EN
            cnt_n    = cnt + 16'd1;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= NORMAL;
            held             <= '0;
            held_v           <= 1'b0;
            err              <= 1'b0;
            m_axis.tvalid    <= 1'b0;
            m_axis.tdata     <= '0;
            m_axis.tlast     <= 1'b0;
            m_axis.tuser     <= 1'b0;
            error_bad_escape <= 1'b0;
        end else begin
            state            <= state_n;
            held             <= held_n;
            held_v           <= held_v_n;
            err              <= err_n;
            error_bad_escape <= bad_esc;
            if (emit) begin
                m_axis.tvalid <= 1'b1;
                m_axis.tdata  <= held;
                m_axis.tlast  <= emit_last;
                m_axis.tuser  <= emit_user;
            end else if (m_axis.tready) begin
                m_axis.tvalid <= 1'b0;
            end
        end
    end

`ifdef SLIP_DECODE_LEN_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt            <= '0;
            error_overflow <= 1'b0;
        end else begin
            cnt            <= cnt_n;
            error_overflow <= ovf;
        end
    end
`else
    assign error_overflow = 1'b0;
`endif
endmodule

// File: tb/tb_uart_slip_decoder.sv
// tb_uart_slip_decoder: scoreboard bench for the SLIP decoder with directed frames.
module tb_uart_slip_decoder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic err_be, err_ov;
    always #5 clk = ~clk;

    uart_slip_decoder_if s_if ();
    uart_slip_decoder_if m_if ();

`ifdef SLIP_DECODE_LEN_CHECK_EN
    localparam int ML = 4;
`else
    localparam int ML = 1518;
`endif

    uart_slip_decoder #(.MAX_LEN(ML)) dut (
        .clk(clk),
        .rst(rst),
        .s_axis(s_if.slave),
        .m_axis(m_if.master),
        .error_bad_escape(err_be),
        .error_overflow(err_ov)
    );

    int total = 0;
    int bad = 0;
    int be_cnt = 0;
    int ov_cnt = 0;
    int rmode = 0;
    int cyc = 0;
    logic [9:0] exp_q[$];
    logic [7:0] raw[$];
    logic [9:0] prev;
    bit stalled = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    function automatic logic [9:0] beat(input logic [7:0] d, input logic l, input logic u);
        return {l, u, d};
    endfunction

    // ready driver: 0 = always ready, 1 = random with a 10-cycle low stretch, 2 = never ready
    always @(posedge clk) begin
        #1;
        if (rmode == 1) cyc++;
        m_if.tready = rmode == 0 ? 1'b1 : rmode == 2 ? 1'b0 :
                      (cyc >= 20 && cyc < 30) ? 1'b0 : 1'($urandom_range(0, 1));
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (stalled) chk("stable_while_stalled", {22'd0, m_if.tlast, m_if.tuser, m_if.tdata}, {22'd0, prev});
            if (m_if.tvalid && !m_if.tready) chk("no_accept_when_full", {31'd0, s_if.tready}, 32'd0);
            if (m_if.tvalid && m_if.tready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_beat: got %h required none", {m_if.tlast, m_if.tuser, m_if.tdata});
                end else begin
                    chk("beat", {22'd0, m_if.tlast, m_if.tuser, m_if.tdata}, {22'd0, exp_q.pop_front()});
                end
            end
            stalled = m_if.tvalid && !m_if.tready;
            prev = {m_if.tlast, m_if.tuser, m_if.tdata};
            if (err_be) be_cnt++;
            if (err_ov) ov_cnt++;
        end else begin
            stalled = 1'b0;
        end
    end

    task automatic send(input logic [7:0] b);
        int n = 0;
        s_if.tdata = b;
        s_if.tvalid = 1'b1;
        @(negedge clk);
        while (!s_if.tready && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (n >= 200) chk("send_timeout", 32'(n), 32'd0);
        @(posedge clk);
        #1;
        s_if.tvalid = 1'b0;
    endtask

    task automatic send_all();
        foreach (raw[i]) send(raw[i]);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            n++;
            @(negedge clk);
        end
        @(negedge clk);
        chk("drain_empty", exp_q.size(), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        s_if.tvalid = 1'b0;
        s_if.tdata = 8'h00;
        s_if.tlast = 1'b0;
        s_if.tuser = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_m_tvalid", {31'd0, m_if.tvalid}, 32'd0);
        chk("rst_m_tlast", {31'd0, m_if.tlast}, 32'd0);
        chk("rst_m_tuser", {31'd0, m_if.tuser}, 32'd0);
        chk("rst_m_tdata", {24'd0, m_if.tdata}, 32'd0);
        chk("rst_err_be", {31'd0, err_be}, 32'd0);
        chk("rst_err_ov", {31'd0, err_ov}, 32'd0);
        chk("rst_s_tready", {31'd0, s_if.tready}, 32'd1);
        rst = 1'b0;

        exp_q.push_back(beat(8'h01, 0, 0));
        exp_q.push_back(beat(8'h02, 0, 0));
        exp_q.push_back(beat(8'h03, 1, 0));
        raw = '{8'h01, 8'h02, 8'h03, 8'hC0};
        send_all();
        drain();

        exp_q.push_back(beat(8'hC0, 0, 0));
        exp_q.push_back(beat(8'hDB, 1, 0));
        raw = '{8'hDB, 8'hDC, 8'hDB, 8'hDD, 8'hC0};
        send_all();
        drain();

        exp_q.push_back(beat(8'h05, 1, 0));
        raw = '{8'hC0, 8'hC0, 8'h05, 8'hC0, 8'hC0};
        send_all();
        drain();
        chk("no_bad_escape_yet", be_cnt, 32'd0);

        exp_q.push_back(beat(8'h11, 0, 0));
        exp_q.push_back(beat(8'h33, 1, 1));
        raw = '{8'h11, 8'hDB, 8'h22, 8'h33, 8'hC0};
        send_all();
        drain();
        chk("bad_escape_pulses", be_cnt, 32'd1);

        rmode = 1;
        raw = {};
        for (int i = 0; i < 38; i++) begin
            raw.push_back(8'(8'h10 + i));
            exp_q.push_back(beat(8'(8'h10 + i), 0, 0));
        end
        raw.push_back(8'hDB);
        raw.push_back(8'hDC);
        raw.push_back(8'hC0);
        exp_q.push_back(beat(8'hC0, 1, 0));
        send_all();
        drain();
        rmode = 0;
        @(posedge clk);
        #1;

        rmode = 2;
        @(posedge clk);
        #1;
        send(8'h77);
        send(8'h88);
        chk("pending_before_reset", {31'd0, m_if.tvalid}, 32'd1);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_clears_pending", {31'd0, m_if.tvalid}, 32'd0);
        rst = 1'b0;
        rmode = 0;
        @(posedge clk);
        #1;
        exp_q.push_back(beat(8'h55, 1, 0));
        raw = '{8'hC0, 8'h55, 8'hC0};
        send_all();
        drain();

`ifdef SLIP_DECODE_LEN_CHECK_EN
        exp_q.push_back(beat(8'h01, 0, 0));
        exp_q.push_back(beat(8'h02, 0, 0));
        exp_q.push_back(beat(8'h03, 0, 0));
        exp_q.push_back(beat(8'h04, 1, 1));
        exp_q.push_back(beat(8'h0A, 1, 0));
        raw = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'hC0, 8'h0A, 8'hC0};
        send_all();
        drain();
        chk("overflow_pulses", ov_cnt, 32'd1);
`else
        chk("overflow_never", ov_cnt, 32'd0);
`endif
        chk("bad_escape_total", be_cnt, 32'd1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/uart_slip_decoder.md
# uart_slip_decoder

Decodes SLIP (RFC 1055) framing from the byte stream produced by the UART receiver and converts it into AXI4-Stream packets with `tlast` and a bad-frame `tuser` flag. It sits directly downstream of the UART receive path: its slave port is driven by the UART's `m_axis_*` output, and its master port feeds packet-level consumers. Escape sequences are resolved, END delimiters become `tlast`, and malformed frames are flagged on their final beat.

## Interface
- `MAX_LEN`, default 1518: maximum decoded bytes per frame. Used only when `SLIP_DECODE_LEN_CHECK_EN` is defined. Range 2..65535.
- `clk` input, 1 bit: single clock for all logic.
- `rst` input, 1 bit: reset, synchronous and active-high.
- `s_axis_tdata` input, 8 bits: raw byte from the UART receiver.
- `s_axis_tvalid` input, 1 bit: raw byte valid.
- `s_axis_tready` output, 1 bit: block accepts the raw byte.
- `m_axis_tdata` output, 8 bits: decoded byte.
- `m_axis_tvalid` output, 1 bit: decoded byte valid.
- `m_axis_tready` input, 1 bit: downstream accepts the decoded byte.
- `m_axis_tlast` output, 1 bit: last byte of the frame.
- `m_axis_tuser` output, 1 bit: frame bad. Meaningful only when `tlast` is 1; 0 on all other beats.
- `error_bad_escape` output, 1 bit: one-cycle pulse when an invalid escape sequence is consumed.
- `error_overflow` output, 1 bit: one-cycle pulse when a frame is truncated. Tied to 0 without the macro.

## Operation
- Codes: END = 0xC0, ESC = 0xDB, ESC_END = 0xDC, ESC_ESC = 0xDD.
- States:
  - NORMAL: data byte (not END, not ESC) → decoded byte. ESC → ESCAPE. END → frame end.
  - ESCAPE:
    - 0xDC → decoded 0xC0; return to NORMAL.
    - 0xDD → decoded 0xDB; return to NORMAL.
    - END → frame end with error flag set; return to NORMAL.
    - Any other byte → byte dropped, `error_bad_escape` pulse, frame error flag set; return to NORMAL.
  - DISCARD (macro only): drop all bytes until END, then return to NORMAL. The END byte emits nothing.
- One-byte hold register (`held`, `held_v`) lets END retroactively mark the previous byte as last.
- Decoded byte arrives:
  - If `held_v` is set, `held` is emitted with tlast=0.
  - The new byte always loads into `held`.
- Frame end (END consumed):
  - If `held_v` is set, `held` is emitted with tlast=1 and tuser = frame error flag. `held_v` and the error flag are cleared.
  - If `held_v` is clear, it is an empty frame: nothing is emitted and the error flag is cleared.
- Consecutive END bytes and a leading END produce no output.
- A frame that is still open keeps its last byte in `held` indefinitely until END arrives. There is no timeout.

## Timing
- `s_axis_tready` = `!m_axis_tvalid || m_axis_tready` (combinational). Bytes in DISCARD state are also gated by this expression, for simplicity.
- Output is a registered stage. A byte emitted by the acceptance in cycle N is valid in cycle N+1.
- Decode latency:
  - A decoded byte appears one cycle after the *next* accepted decoded byte or END.
  - END → `tlast` beat: 1 cycle.
- `m_axis_*` is held stable while `tvalid && !tready`. `tvalid` never drops without a handshake.
- Full throughput: one raw byte per cycle when `m_axis_tready` is held high.
- Error pulses assert in the cycle after the offending byte is accepted and last 1 cycle.
- Reset values:
  - `m_axis_tvalid`, `m_axis_tlast`, `m_axis_tuser`, `m_axis_tdata`, `error_*`: 0.
  - `s_axis_tready`: 1.
  - State: NORMAL; `held_v` = 0; error flag = 0; length counter = 0.
- Reset mid-frame discards the partial frame, any held byte, and any pending output beat. No `tlast` is generated for the discarded frame.

## Configuration
- Macro: `SLIP_DECODE_LEN_CHECK_EN`.
- Defined:
  - A 16-bit counter counts the decoded bytes of the current frame.
  - If a decoded byte arrives when the counter equals MAX_LEN:
    - `held` is emitted with tlast=1, tuser=1.
    - The new byte is dropped.
    - `error_overflow` pulses.
    - The state becomes DISCARD.
  - The counter clears at END and on reset.
  - A frame of exactly MAX_LEN bytes followed by END is good (tuser=0).
- Undefined:
  - No counter, no DISCARD state; frames have unbounded length.
  - `error_overflow` is constant 0.

## Test plan
- Plain frame: in 01 02 03 C0 → out 01, 02, 03 (tlast=1, tuser=0), exactly 3 beats.
- Escapes: in DB DC DB DD C0 → out C0, DB (tlast=1, tuser=0).
- Empty and leading ENDs: in C0 C0 05 C0 C0 → single beat 05 (tlast=1, tuser=0).
- Bad escape: in 11 DB 22 33 C0 → out 11, 33 (tlast=1, tuser=1); `error_bad_escape` pulses once.
- Backpressure: stream 40 bytes plus END with `m_axis_tready` toggled randomly and held low for 10 cycles. Output matches the reference decode and is stable while stalled; no input is accepted while the output is full and not ready.
- Overflow (macro, MAX_LEN=4): in 01..06 C0 0A C0 → out 01 02 03 04 (tlast=1, tuser=1), `error_overflow` pulse, then 0A (tlast=1, tuser=0).
